// File: rtl/iq_ram_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_ram_scheduler_if : capture, playback and RAM signals of the scheduler |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface iq_ram_scheduler_if #(
   parameter int ADDR_W = 16
);
   logic              cap_valid;
   logic [15:0]       cap_q;
   logic [15:0]       cap_i;
   logic              cap_ready;
   logic              pb_req;
   logic              pb_valid;
   logic [15:0]       pb_data;
   logic [ADDR_W-2:0] delay;
   logic              pb_overrun;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [15:0]       ram_wdata;
   logic              ram_rd;
   logic [15:0]       ram_rdata;

   modport slave (
      input  cap_valid, cap_q, cap_i, pb_req, delay, ram_rdata,
      output cap_ready, pb_valid, pb_data, pb_overrun,
             ram_addr, ram_we, ram_wdata, ram_rd
   );

   modport master (
      output cap_valid, cap_q, cap_i, pb_req, delay, ram_rdata,
      input  cap_ready, pb_valid, pb_data, pb_overrun,
             ram_addr, ram_we, ram_wdata, ram_rd
   );
endinterface
`default_nettype wire

// File: rtl/iq_ram_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_ram_scheduler : arbitrates I/Q capture writes and delayed playback    |
// | reads onto one RAM. Option: IQ_SCHED_FILL_GATE_EN (midscale until fill). |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module iq_ram_scheduler #(
   parameter int ADDR_W = 16
) (
   input  logic               M100CLK,
   input  logic               reset,
   iq_ram_scheduler_if.slave  bus
);
   localparam int PW = ADDR_W - 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR_Q = 3'd1;
   localparam logic [2:0] S_WR_I = 3'd2;
   localparam logic [2:0] S_RD_Q = 3'd3;
   localparam logic [2:0] S_RD_I = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_pair;
   logic              r_buf_full;
   logic [15:0]       r_buf_q;
   logic [15:0]       r_buf_i;
   logic              r_pb_pending;
   logic              r_pb_overrun;
   logic              r_last_pb;
   logic              r_rd_d1;
   logic              r_pb_valid;
   logic [15:0]       r_pb_data;
   logic              w_cap_ready;
   logic              w_cap_acc;
   logic              w_grant_wr;
   logic              w_grant_rd;
   logic              w_ram_we;
   logic              w_ram_rd;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [15:0]       w_ram_wdata;
   logic [15:0]       w_pb_word;

   assign w_cap_ready = ~r_buf_full & ~reset;
   assign w_cap_acc   = bus.cap_valid & w_cap_ready;

   // Round-robin: capture wins a tie only when playback was served last.
   assign w_grant_wr = r_buf_full & (~r_pb_pending | r_last_pb);
   assign w_grant_rd = r_pb_pending & ~w_grant_wr;

   always_ff @(posedge M100CLK) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_grant_wr)      w_state_nxt = S_WR_Q;
            else if (w_grant_rd) w_state_nxt = S_RD_Q;
            else                 w_state_nxt = S_IDLE;
         end
         S_WR_Q:  w_state_nxt = S_WR_I;
         S_RD_Q:  w_state_nxt = S_RD_I;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_rd    = 1'b0;
      w_ram_addr  = '0;
      w_ram_wdata = '0;
      if (!reset) begin
         case (r_state)
            S_WR_Q: begin
               w_ram_we    = 1'b1;
               w_ram_addr  = {r_wr_ptr, 1'b0};
               w_ram_wdata = r_buf_q;
            end
            S_WR_I: begin
               w_ram_we    = 1'b1;
               w_ram_addr  = {r_wr_ptr, 1'b1};
               w_ram_wdata = r_buf_i;
            end
            S_RD_Q: begin
               w_ram_rd   = 1'b1;
               w_ram_addr = {r_rd_pair, 1'b0};
            end
            S_RD_I: begin
               w_ram_rd   = 1'b1;
               w_ram_addr = {r_rd_pair, 1'b1};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge M100CLK) begin
      if (reset) begin
         r_buf_full <= 1'b0;
         r_buf_q    <= '0;
         r_buf_i    <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (r_state == S_WR_I) begin
            r_buf_full <= 1'b0;
            r_wr_ptr   <= r_wr_ptr + PW'(1);
         end else if (w_cap_acc) begin
            r_buf_full <= 1'b1;
            r_buf_q    <= bus.cap_q;
            r_buf_i    <= bus.cap_i;
         end
      end
   end

   always_ff @(posedge M100CLK) begin
      if (reset) begin
         r_last_pb <= 1'b1;
         r_rd_pair <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_grant_wr) begin
            r_last_pb <= 1'b0;
         end else if (w_grant_rd) begin
            r_last_pb <= 1'b1;
            r_rd_pair <= r_wr_ptr - PW'(1) - bus.delay;
         end
      end
   end

   // A request seen while one is still pending is dropped and flagged.
   always_ff @(posedge M100CLK) begin
      if (reset) begin
         r_pb_pending <= 1'b0;
         r_pb_overrun <= 1'b0;
      end else begin
         if (bus.pb_req) begin
            if (r_pb_pending) r_pb_overrun <= 1'b1;
            else              r_pb_pending <= 1'b1;
         end
         if (r_state == S_RD_I) r_pb_pending <= 1'b0;
      end
   end

`ifdef IQ_SCHED_FILL_GATE_EN
   localparam logic [ADDR_W-1:0] FILL_MAX = {1'b1, {PW{1'b0}}};
   logic [ADDR_W-1:0] r_fill;

   always_ff @(posedge M100CLK) begin
      if (reset)                                    r_fill <= '0;
      else if (r_state == S_WR_I && r_fill != FILL_MAX) r_fill <= r_fill + ADDR_W'(1);
   end

   assign w_pb_word = (r_fill <= {1'b0, bus.delay}) ? 16'h8000 : bus.ram_rdata;
`else
   assign w_pb_word = bus.ram_rdata;
`endif

   // Clearing r_rd_d1 on reset discards a read already issued to the RAM.
   always_ff @(posedge M100CLK) begin
      if (reset) begin
         r_rd_d1    <= 1'b0;
         r_pb_valid <= 1'b0;
         r_pb_data  <= '0;
      end else begin
         r_rd_d1    <= w_ram_rd;
         r_pb_valid <= r_rd_d1;
         if (r_rd_d1) r_pb_data <= w_pb_word;
      end
   end

   assign bus.cap_ready  = w_cap_ready;
   assign bus.pb_valid   = r_pb_valid;
   assign bus.pb_data    = r_pb_data;
   assign bus.pb_overrun = r_pb_overrun;
   assign bus.ram_we     = w_ram_we;
   assign bus.ram_rd     = w_ram_rd;
   assign bus.ram_addr   = w_ram_addr;
   assign bus.ram_wdata  = w_ram_wdata;
endmodule
`default_nettype wire

// File: tb/tb_iq_ram_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iq_ram_scheduler : scoreboard bench with RAM model and pair-level     |
// | reference model. Revision 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_iq_ram_scheduler;
   localparam int AW    = 4;
   localparam int PW    = AW - 1;
   localparam int NPAIR = 1 << PW;

   logic M100CLK = 1'b0;
   logic reset   = 1'b1;
   always #5 M100CLK = ~M100CLK;

   iq_ram_scheduler_if #(.ADDR_W(AW)) bus ();
   iq_ram_scheduler #(.ADDR_W(AW)) dut (.M100CLK(M100CLK), .reset(reset), .bus(bus));

   logic [15:0] ram [0:(1<<AW)-1] = '{default: 16'h0};
   always @(posedge M100CLK) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_rd) bus.ram_rdata <= ram[bus.ram_addr];
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   logic [15:0]   exp_pb[$];
   int            rd_cyc[$];

   logic [15:0] m_mem [0:(1<<AW)-1] = '{default: 16'h0};
   int  m_wcnt     = 0;
   bit  m_last_pb  = 1'b1;
   bit  m_overrun  = 1'b0;
   int  checks     = 0;
   int  fails      = 0;
   int  cyc        = 0;
   int  last_wr_cyc = 0;

   always @(posedge M100CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      fails++;
      $display("FAIL %s: got %h, nothing expected (cycle %0d)", name, act, cyc);
   endtask

   // Reference model: pairs land at successive slots; a read fetches the slot
   // written delay+1 pairs before the current write position.
   task automatic model_write(input logic [15:0] q, input logic [15:0] i);
      int p;
      p = m_wcnt % NPAIR;
      exp_wr.push_back({AW'(2*p),   q});
      exp_wr.push_back({AW'(2*p+1), i});
      m_mem[2*p]   = q;
      m_mem[2*p+1] = i;
      m_wcnt++;
      m_last_pb = 1'b0;
   endtask

   task automatic model_read(input int dly);
      int p;
      int fill;
      bit gate;
      p    = (((m_wcnt - 1 - dly) % NPAIR) + NPAIR) % NPAIR;
      fill = (m_wcnt < NPAIR) ? m_wcnt : NPAIR;
      gate = 1'b0;
`ifdef IQ_SCHED_FILL_GATE_EN
      gate = (fill <= dly);
`endif
      exp_rd.push_back(AW'(2*p));
      exp_rd.push_back(AW'(2*p+1));
      exp_pb.push_back(gate ? 16'h8000 : m_mem[2*p]);
      exp_pb.push_back(gate ? 16'h8000 : m_mem[2*p+1]);
      m_last_pb = 1'b1;
   endtask

   always @(negedge M100CLK) begin
      chk("we_rd_exclusive", 32'(bus.ram_we & bus.ram_rd), 32'd0);
      if (bus.ram_we) begin
         if (exp_wr.size() == 0) unexpected("ram_write", 32'(bus.ram_addr));
         else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("ram_write_addr", 32'(bus.ram_addr), 32'(e.addr));
            chk("ram_write_data", 32'(bus.ram_wdata), 32'(e.data));
            if (bus.ram_addr[0]) chk("wr_pair_consecutive", 32'(cyc), 32'(last_wr_cyc + 1));
         end
         last_wr_cyc = cyc;
      end
      if (bus.ram_rd) begin
         rd_cyc.push_back(cyc);
         if (exp_rd.size() == 0) unexpected("ram_read", 32'(bus.ram_addr));
         else chk("ram_read_addr", 32'(bus.ram_addr), 32'(exp_rd.pop_front()));
      end
      if (bus.pb_valid) begin
         if (exp_pb.size() == 0) unexpected("pb_valid", 32'(bus.pb_data));
         else chk("pb_data", 32'(bus.pb_data), 32'(exp_pb.pop_front()));
         if (rd_cyc.size() == 0) unexpected("pb_without_read", 32'(cyc));
         else chk("pb_latency", 32'(cyc), 32'(rd_cyc.pop_front() + 2));
      end
   end

   task automatic tick();
      @(posedge M100CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.cap_valid = 1'b0;
      bus.pb_req    = 1'b0;
      idle(2);
      #1;
      chk("rst_pb_valid",   32'(bus.pb_valid),   32'd0);
      chk("rst_pb_data",    32'(bus.pb_data),    32'd0);
      chk("rst_ram_we",     32'(bus.ram_we),     32'd0);
      chk("rst_ram_rd",     32'(bus.ram_rd),     32'd0);
      chk("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
      chk("rst_pb_overrun", 32'(bus.pb_overrun), 32'd0);
      chk("rst_cap_ready",  32'(bus.cap_ready),  32'd0);
      reset = 1'b0;
      m_wcnt    = 0;
      m_last_pb = 1'b1;
      m_overrun = 1'b0;
      tick();
      chk("post_rst_cap_ready", 32'(bus.cap_ready), 32'd1);
   endtask

   task automatic capture(input logic [15:0] q, input logic [15:0] i);
      int n;
      n = 0;
      bus.cap_valid = 1'b1;
      bus.cap_q     = q;
      bus.cap_i     = i;
      model_write(q, i);
      while (!bus.cap_ready && n < 20) begin
         tick();
         n++;
      end
      chk("cap_handshake", 32'(bus.cap_ready), 32'd1);
      tick();
      bus.cap_valid = 1'b0;
   endtask

   task automatic playback(input int dly, input bit twice);
      bus.delay  = PW'(dly);
      bus.pb_req = 1'b1;
      model_read(dly);
      tick();
      if (twice) begin
         m_overrun = 1'b1;
         tick();
      end
      bus.pb_req = 1'b0;
   endtask

   task automatic contention(input logic [15:0] q, input logic [15:0] i, input int dly);
      bus.cap_valid = 1'b1;
      bus.cap_q     = q;
      bus.cap_i     = i;
      bus.delay     = PW'(dly);
      bus.pb_req    = 1'b1;
      if (m_last_pb) begin
         model_write(q, i);
         model_read(dly);
      end else begin
         model_read(dly);
         model_write(q, i);
      end
      tick();
      bus.cap_valid = 1'b0;
      bus.pb_req    = 1'b0;
   endtask

   task automatic settle();
      idle(14);
      chk("pb_overrun", 32'(bus.pb_overrun), 32'(m_overrun));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cap_valid = 1'b0;
      bus.cap_q     = '0;
      bus.cap_i     = '0;
      bus.pb_req    = 1'b0;
      bus.delay     = '0;
      bus.ram_rdata = '0;
      #1;
      do_reset();

      capture(16'h1234, 16'h5678);
      settle();
      capture(16'hA001, 16'hB001);
      settle();
      capture(16'hA002, 16'hB002);
      settle();
      playback(1, 1'b0);
      settle();

      contention(16'hC001, 16'hD001, 0);
      settle();
      contention(16'hC002, 16'hD002, 2);
      settle();

      playback(0, 1'b1);
      settle();
      do_reset();

      for (int k = 0; k < 9; k++) begin
         capture(16'(16'h1000 + k), 16'(16'h2000 + k));
         settle();
      end
      playback(0, 1'b0);
      settle();

      do_reset();
      capture(16'h0F0F, 16'hF0F0);
      settle();
      capture(16'h3C3C, 16'hC3C3);
      settle();
      playback(5, 1'b0);
      settle();

      bus.delay  = PW'(1);
      bus.pb_req = 1'b1;
      tick();
      bus.pb_req = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("rd_gated_by_reset", 32'(bus.ram_rd), 32'd0);
      tick();
      reset     = 1'b0;
      m_wcnt    = 0;
      m_last_pb = 1'b1;
      m_overrun = 1'b0;
      settle();

      for (int n = 0; n < 80; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r <= 3)      capture(16'($urandom), 16'($urandom));
         else if (r <= 6) playback(int'($urandom_range(0, NPAIR-1)), 1'b0);
         else if (r <= 8) contention(16'($urandom), 16'($urandom), int'($urandom_range(0, NPAIR-1)));
         else             do_reset();
         settle();
      end

      idle(10);
      chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
      chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
      chk("exp_pb_drained", 32'(exp_pb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/iq_ram_scheduler.md
IQ_RAM_SCHEDULER -- requirements
Module: iq_ram_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the RAM word-address width; the pair index is ADDR_W-1 bits.
REQ-002 The block SHALL have port M100CLK, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port cap_valid, input, 1, meaning a capture I/Q pair is offered.
REQ-005 The block SHALL have ports cap_q and cap_i, input, 16 each, carrying the unsigned offset-binary capture samples.
REQ-006 The block SHALL have port cap_ready, output, 1, equal to NOT buf_full AND NOT reset.
REQ-007 The block SHALL have port pb_req, input, 1, a one-cycle request to play back one pair.
REQ-008 The block SHALL have ports pb_valid, output, 1, and pb_data, output, 16, forming the playback word stream, Q word first, then I word.
REQ-009 The block SHALL have port delay, input, ADDR_W-1, meaning the playback delay in pairs.
REQ-010 The block SHALL have RAM port outputs ram_addr (ADDR_W), ram_we (1), ram_wdata (16) and ram_rd (1), and RAM input ram_rdata (16), with a fixed read latency of 1 cycle.
REQ-011 The block SHALL have port pb_overrun, output, 1, a sticky flag.

Function
REQ-012 A capture pair SHALL be accepted when cap_valid and cap_ready are both high; the pair is stored in a one-pair buffer and buf_full is set.
REQ-013 A pb_req pulse SHALL set pb_pending; a pb_req arriving while pb_pending is already set SHALL set pb_overrun and SHALL be dropped.
REQ-014 The FSM SHALL have states IDLE, WR_Q, WR_I, RD_Q and RD_I, and each non-IDLE state SHALL last exactly 1 cycle.
REQ-015 From IDLE, the FSM SHALL go to WR_Q if only buf_full is set and to RD_Q if only pb_pending is set; if both are set, it SHALL grant the requester not served last (round-robin); if neither is set, it SHALL stay in IDLE.
REQ-016 After WR_Q the FSM SHALL go to WR_I, after RD_Q to RD_I, and after WR_I or RD_I back to IDLE; a granted pair SHALL never be split.
REQ-017 In WR_Q the block SHALL drive ram_we=1, ram_addr={wr_ptr,0} and ram_wdata=Q.
REQ-018 In WR_I the block SHALL drive ram_we=1, ram_addr={wr_ptr,1} and ram_wdata=I; buf_full SHALL clear and wr_ptr SHALL increment, wrapping from 2^(ADDR_W-1)-1 to 0.
REQ-019 On entry to RD_Q the block SHALL latch rd_pair = wr_ptr - 1 - delay, modulo 2^(ADDR_W-1).
REQ-020 In RD_Q the block SHALL drive ram_rd=1 and ram_addr={rd_pair,0}.
REQ-021 In RD_I the block SHALL drive ram_rd=1 and ram_addr={rd_pair,1}, and pb_pending SHALL clear.
REQ-022 When ram_rd is issued in cycle N, pb_valid SHALL be 1 and pb_data SHALL equal the registered ram_rdata in cycle N+2.
REQ-023 A cap_valid arriving during WR_I SHALL be accepted in the following cycle at the earliest, since cap_ready is taken from registered buf_full.
REQ-024 ram_we and ram_rd SHALL never both be high in the same cycle.

Reset
REQ-025 Reset SHALL force state=IDLE, wr_ptr=0, buf_full=0, pb_pending=0, pb_overrun=0, ram_we=0, ram_rd=0, pb_valid=0, pb_data=0 and ram_addr=0.
REQ-026 Reset SHALL set the last-served requester to playback, so capture wins the first contention.
REQ-027 A reset asserted mid-pair SHALL abort the pair; the read data still in flight SHALL NOT produce pb_valid.

Configuration
REQ-028 With IQ_SCHED_FILL_GATE_EN defined, a pair-fill counter SHALL saturate at 2^(ADDR_W-1); playback of a pair SHALL still execute, but pb_data SHALL be forced to 16'h8000 (midscale) while the counter is at most delay.
REQ-029 Without IQ_SCHED_FILL_GATE_EN, there SHALL be no fill counter, and pb_data SHALL always equal the RAM data.

Verification
REQ-030 Capture Q=16'h1234, I=16'h5678 after reset -> writes addr 0 = 16'h1234 and addr 1 = 16'h5678 in consecutive cycles; wr_ptr=1.
REQ-031 3 pairs captured, delay=1, pb_req -> reads addr 2 and 3; pb_valid 2 cycles after each read, carrying pair-1 data Q then I.
REQ-032 cap_valid and pb_req both pending in the same IDLE cycle, repeated twice -> order WR, RD, WR, RD.
REQ-033 pb_req pulsed twice before RD_I -> one playback pair only, and pb_overrun=1 until reset.
REQ-034 ADDR_W=4, 9 pairs captured -> 9th pair written at addr 0/1, wr_ptr=1.
REQ-035 With IQ_SCHED_FILL_GATE_EN defined, delay=5 and 2 pairs captured, pb_req -> pb_data 16'h8000 twice; reset asserted during RD_Q -> no pb_valid.
